// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate-bank sweep checker: output indices and FSM states.
package gate_sweep_pkg;

  localparam int NUM_GATES = 7;

  localparam int IDX_AND  = 0;
  localparam int IDX_OR   = 1;
  localparam int IDX_NAND = 2;
  localparam int IDX_NOR  = 3;
  localparam int IDX_XOR  = 4;
  localparam int IDX_XNOR = 5;
  localparam int IDX_NOT  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Reference model of the gate bank: WIDTH-input reductions plus NOT of the MSB.
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0]     stim,
  output logic [NUM_GATES-1:0] expected
);

  // Expected value of every bank output for the current vector
  always_comb begin
    expected            = '0;
    expected[IDX_AND]   = &stim;
    expected[IDX_OR]    = |stim;
    expected[IDX_NAND]  = ~&stim;
    expected[IDX_NOR]   = ~|stim;
    expected[IDX_XOR]   = ^stim;
    expected[IDX_XNOR]  = ~^stim;
    expected[IDX_NOT]   = ~stim[WIDTH-1];
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive self-checking sweep of the gate bank.
// Optional GATE_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first failing vector.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_GATES-1:0] resp,
  output logic [WIDTH-1:0]     stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [WIDTH:0]       err_count,
  output logic [WIDTH-1:0]     first_fail_vec,
  output logic [NUM_GATES-1:0] first_fail_mask
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  sweep_state_t          state_q, state_d;
  logic [3:0]            cnt_q;
  logic [WIDTH-1:0]      stim_q;
  logic [WIDTH:0]        err_q;
  logic [WIDTH-1:0]      ffv_q;
  logic [NUM_GATES-1:0]  ffm_q;
  logic                  pass_q;

  logic [NUM_GATES-1:0]  expected;
  logic [NUM_GATES-1:0]  mismatch;
  logic                  any_mis;
  logic                  last_vec;

  logic                  clear;
  logic                  record;
  logic                  advance;
  logic                  finish;

  gate_ref_model #(.WIDTH(WIDTH)) u_ref (
    .stim     (stim_q),
    .expected (expected)
  );

  assign mismatch = resp ^ expected;
  assign any_mis  = |mismatch;
  assign last_vec = &stim_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath strobes
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    record  = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WAIT;
          clear   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        record = any_mis;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        if (any_mis || last_vec) begin
`else
        if (last_vec) begin
`endif
          state_d = ST_DONE;
          finish  = 1'b1;
        end else begin
          state_d = ST_WAIT;
          advance = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Settle counter, vector counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      stim_q <= '0;
      err_q  <= '0;
      ffv_q  <= '0;
      ffm_q  <= '0;
      pass_q <= 1'b0;
    end else if (clear) begin
      cnt_q  <= SETTLE_LOAD;
      stim_q <= '0;
      err_q  <= '0;
      ffv_q  <= '0;
      ffm_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      if (state_q == ST_WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      if (record) begin
        err_q <= err_q + (WIDTH+1)'(1);
        if (err_q == '0) begin
          ffv_q <= stim_q;
          ffm_q <= mismatch;
        end
      end
      if (advance) begin
        stim_q <= stim_q + WIDTH'(1);
        cnt_q  <= SETTLE_LOAD;
      end
      // pass is decided from the count as it will be after this CHECK
      if (finish) pass_q <= ~record && (err_q == '0);
    end
  end

  assign stim            = stim_q;
  assign busy            = (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign done            = (state_q == ST_DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_fail_vec  = ffv_q;
  assign first_fail_mask = ffm_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (WIDTH=2/SETTLE=1 with fault injection,
// WIDTH=3/SETTLE=2), a cycle-level sweep model and directed literal checks.
module tb_gate_sweep_checker;

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    int stim; int busy; int done; int pass; int err; int ffv; int ffm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  bit   fault_a = 1'b0;

  logic [6:0] resp_a, resp_b;
  logic [1:0] stim_a, ffv_a;
  logic [2:0] stim_b, ffv_b, err_a;
  logic [3:0] err_b;
  logic [6:0] ffm_a, ffm_b;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Truth of each gate output, from plain arithmetic on the vector value
  function automatic logic [6:0] truth(int w, int v);
    logic [6:0] r;
    int n = 1 << w;
    r[0] = (v == n - 1);
    r[1] = (v != 0);
    r[2] = !r[0];
    r[3] = !r[1];
    r[4] = (($countones(v) % 2) == 1);
    r[5] = !r[4];
    r[6] = (v < n / 2);
    return r;
  endfunction

  // Gate bank under test, optionally with XOR stuck-at-0
  function automatic logic [6:0] bank(int w, int v, bit fault);
    logic [6:0] r = truth(w, v);
    if (fault) r[4] = 1'b0;
    return r;
  endfunction

  function automatic int total_cycles(int w, int s, bit fault);
    int n = 1 << w;
    for (int v = 0; v < n; v++)
      if (STOP && bank(w, v, fault) != truth(w, v)) return (v + 1) * (s + 1);
    return n * (s + 1);
  endfunction

  // Outputs k edges after the edge that accepted start
  function automatic exp_t model(int w, int s, bit fault, bit act, int k);
    exp_t e = '{default: 0};
    int n = 1 << w;
    int l = s + 1;
    int t = total_cycles(w, s, fault);
    int checked;
    if (!act) return e;
    if (k < t) begin
      e.busy = 1;
      e.stim = k / l;
      checked = k / l;
    end else begin
      e.done = 1;
      checked = t / l;
      e.stim = checked - 1;
    end
    for (int v = 0; v < checked; v++) begin
      logic [6:0] m = bank(w, v, fault) ^ truth(w, v);
      if (m != 0) begin
        if (e.err == 0) begin
          e.ffv = v;
          e.ffm = int'(m);
        end
        e.err++;
      end
    end
    if (e.done == 1) e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  assign resp_a = bank(2, int'(stim_a), fault_a);
  assign resp_b = bank(3, int'(stim_b), 1'b0);

  gate_sweep_checker #(.WIDTH(2), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .resp(resp_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail_vec(ffv_a), .first_fail_mask(ffm_a)
  );

  gate_sweep_checker #(.WIDTH(3), .SETTLE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .resp(resp_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail_vec(ffv_b), .first_fail_mask(ffm_b)
  );

  // Model progress: k counts edges since the accepted start
  bit act_a, act_b, flt_a;
  int k_a, k_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_a <= 1'b0; act_b <= 1'b0; flt_a <= 1'b0;
      k_a <= 0; k_b <= 0;
    end else begin
      if (act_a && k_a < total_cycles(2, 1, flt_a)) k_a <= k_a + 1;
      else if (start_a) begin act_a <= 1'b1; k_a <= 0; flt_a <= fault_a; end
      if (act_b && k_b < total_cycles(3, 2, 1'b0)) k_b <= k_b + 1;
      else if (start_b) begin act_b <= 1'b1; k_b <= 0; end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    exp_t ea, eb;
    if (rst_n) begin
      ea = model(2, 1, flt_a, act_a, k_a);
      eb = model(3, 2, 1'b0, act_b, k_b);
      chk("a_stim", int'(stim_a), ea.stim);
      chk("a_busy", int'(busy_a), ea.busy);
      chk("a_done", int'(done_a), ea.done);
      chk("a_pass", int'(pass_a), ea.pass);
      chk("a_err",  int'(err_a),  ea.err);
      chk("a_ffv",  int'(ffv_a),  ea.ffv);
      chk("a_ffm",  int'(ffm_a),  ea.ffm);
      chk("b_stim", int'(stim_b), eb.stim);
      chk("b_busy", int'(busy_b), eb.busy);
      chk("b_done", int'(done_b), eb.done);
      chk("b_pass", int'(pass_b), eb.pass);
      chk("b_err",  int'(err_b),  eb.err);
      chk("b_ffv",  int'(ffv_b),  eb.ffv);
      chk("b_ffm",  int'(ffm_b),  eb.ffm);
    end
  end

  // Start a sweep from a negedge; n = edges after the start edge until done is seen
  task automatic sweep(input bit sel, input int pulse_at, output int n, output int busy_n);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    n = 0;
    busy_n = int'(sel ? busy_b : busy_a);
    chk("restart_done_low", int'(sel ? done_b : done_a), 0);
    chk("restart_err_clear", sel ? int'(err_b) : int'(err_a), 0);
    while (!(sel ? done_b : done_a) && n < 2000) begin
      if (n == pulse_at) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
      busy_n += int'(sel ? busy_b : busy_a);
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  function automatic int all_a();
    return int'(stim_a) + int'(busy_a) + int'(done_a) + int'(pass_a)
         + int'(err_a) + int'(ffv_a) + int'(ffm_a);
  endfunction

  initial begin
    int n, bn;
    #1;
    chk("reset_outputs_a", all_a(), 0);
    chk("reset_busy_b", int'(busy_b), 0);
    chk("reset_done_b", int'(done_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct bank, WIDTH=2 SETTLE=1
    sweep(1'b0, -1, n, bn);
    chk("a_ok_latency", n, 8);
    chk("a_ok_stim", int'(stim_a), 3);
    chk("a_ok_pass", int'(pass_a), 1);
    chk("a_ok_err", int'(err_a), 0);

    // XOR stuck-at-0
    fault_a = 1'b1;
    sweep(1'b0, -1, n, bn);
    if (STOP) begin
      chk("a_fault_latency", n, 4);
      chk("a_fault_err", int'(err_a), 1);
      chk("a_fault_stim", int'(stim_a), 1);
    end else begin
      chk("a_fault_latency", n, 8);
      chk("a_fault_err", int'(err_a), 2);
      chk("a_fault_stim", int'(stim_a), 3);
    end
    chk("a_fault_ffv", int'(ffv_a), 1);
    chk("a_fault_ffm", int'(ffm_a), 7'b0010000);
    chk("a_fault_pass", int'(pass_a), 0);
    fault_a = 1'b0;

    // Restart from DONE with a stray start while busy
    sweep(1'b0, 3, n, bn);
    chk("a_pulse_latency", n, 8);
    chk("a_pulse_pass", int'(pass_a), 1);

    // WIDTH=3 SETTLE=2, then immediate restart on first done cycle
    sweep(1'b1, -1, n, bn);
    chk("b_latency", n, 24);
    chk("b_busy_cycles", bn, 24);
    chk("b_pass", int'(pass_b), 1);
    sweep(1'b1, -1, n, bn);
    chk("b_again_latency", n, 24);
    chk("b_again_busy_cycles", bn, 24);

    // Reset during WAIT of vector 2
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("a_mid_stim", int'(stim_a), 2);
    chk("a_mid_busy", int'(busy_a), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("a_mid_reset_outputs", all_a(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep(1'b0, -1, n, bn);
    chk("a_post_reset_latency", n, 8);
    chk("a_post_reset_pass", int'(pass_a), 1);
    chk("a_post_reset_stim", int'(stim_a), 3);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
